modinv_seq: RTL and testbench

- Multi-cycle sequencer for modular inverse d = e^-1 mod phi, used in the RSA key-generation path.
- Runs extended Euclid one step at a time on a shared bit-serial shift-subtract divider, so no combinational loop or wide multiplier is needed.
- Accepts a start pulse, walks the quotient/Bezout update sequence, and returns d with a valid flag.

---
 rtl/modinv_seq_if.sv | 33 +++
 rtl/modinv_seq.sv | 159 +++++++++++++++
 tb/tb_modinv_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/modinv_seq_if.sv
// ============================================================================
//  Module      : modinv_seq_if
//  Description : Start/operand/result bundle for the modular-inverse
//                sequencer. The master drives start/e/phi and the slave
//                returns busy/done/valid/d/steps.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface modinv_seq_if #(
    parameter int WIDTH = 128
);
    logic             start;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] phi;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] d;
    logic [15:0]      steps;

    modport master (
        output start, e, phi,
        input  busy, done, valid, d, steps
    );

    modport slave (
        input  start, e, phi,
        output busy, done, valid, d, steps
    );
endinterface

`default_nettype wire

// File: rtl/modinv_seq.sv
// ============================================================================
//  Module      : modinv_seq
//  Description : Sequential modular inverse d = e^-1 mod phi. Extended
//                Euclid, one quotient per step, each quotient produced by a
//                WIDTH-cycle restoring divider that folds the Bezout update
//                (t - q*nt) into the same bit-serial pass.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modinv_seq #(
    parameter int WIDTH = 128
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    modinv_seq_if.slave mi_if
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = WIDTH + 2;
    localparam logic signed [AW-1:0] C_ZERO = '0;
    localparam logic [KW-1:0]        C_KTOP = KW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_DIV  = 3'd2,
        S_UPD  = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       e_q, phi_q;
    logic [WIDTH-1:0]       r_q, nr_q, rem_q;
    logic signed [AW-1:0]   t_q, nt_q, acc_q;
    logic [KW-1:0]          k_q;
    logic                   busy_q, done_q, valid_q;
    logic [WIDTH-1:0]       d_q;
    logic [15:0]            steps_q;

    // One restoring-division bit: shift in r[k], trial-subtract nr, and
    // subtract nt<<k from the Bezout accumulator when the quotient bit is 1.
    // Only the low AW bits of the shifted term can affect a AW-bit result,
    // so the shift is formed directly at AW bits.
    logic [WIDTH:0]         rem_sh_d;
    logic                   take_d;
    logic [WIDTH-1:0]       rem_d;
    logic signed [AW-1:0]   acc_d;

    assign rem_sh_d = {rem_q, r_q[k_q]};
    assign take_d   = (rem_sh_d >= {1'b0, nr_q});
    assign rem_d    = take_d ? (rem_sh_d[WIDTH-1:0] - nr_q) : rem_sh_d[WIDTH-1:0];
    assign acc_d    = take_d ? (acc_q - (nt_q <<< k_q)) : acc_q;

    assign mi_if.busy  = busy_q;
    assign mi_if.done  = done_q;
    assign mi_if.valid = valid_q;
    assign mi_if.d     = d_q;
    assign mi_if.steps = steps_q;

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            e_q     <= '0;
            phi_q   <= '0;
            r_q     <= '0;
            nr_q    <= '0;
            rem_q   <= '0;
            t_q     <= '0;
            nt_q    <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            d_q     <= '0;
            steps_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (mi_if.start) begin
                        e_q     <= mi_if.e;
                        phi_q   <= mi_if.phi;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        d_q     <= '0;
                        state_q <= S_INIT;
                    end
                end
                S_INIT: begin
                    t_q     <= '0;
                    nt_q    <= AW'(1);
                    acc_q   <= '0;
                    rem_q   <= '0;
                    k_q     <= C_KTOP;
                    steps_q <= '0;
                    if ((phi_q < WIDTH'(2)) || (e_q >= phi_q) || (e_q == '0)) begin
                        // r is cleared as well so phi=1 cannot look like gcd=1.
                        r_q     <= '0;
                        nr_q    <= '0;
                        state_q <= S_FIX;
                    end else begin
                        r_q     <= phi_q;
                        nr_q    <= e_q;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    acc_q <= acc_d;
                    if (k_q == '0) begin
                        state_q <= S_UPD;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                S_UPD: begin
                    t_q   <= nt_q;
                    nt_q  <= acc_q;
                    r_q   <= nr_q;
                    nr_q  <= rem_q;
                    // Next division starts with acc equal to the new t.
                    acc_q <= nt_q;
                    rem_q <= '0;
                    k_q   <= C_KTOP;
                    if (steps_q != 16'hFFFF) begin
                        steps_q <= steps_q + 16'd1;
                    end
                    state_q <= (rem_q == '0) ? S_FIX : S_DIV;
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (r_q == WIDTH'(1)) begin
                        valid_q <= 1'b1;
                        // Low WIDTH bits of the AW-bit sum t+phi.
                        d_q     <= (t_q < C_ZERO) ? (t_q[WIDTH-1:0] + phi_q) : t_q[WIDTH-1:0];
                    end else begin
                        valid_q <= 1'b0;
                        d_q     <= '0;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_modinv_seq.sv
// ============================================================================
//  Module      : tb_modinv_seq
//  Description : Self-checking bench for modinv_seq at WIDTH=16 and 128.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modinv_seq;

    localparam int BUDGET = 20000;

    logic clk;
    logic rst_n;
    logic sel128;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         v;
        logic [127:0] d;
        logic [15:0]  steps;
        int           lat;
    } exp_t;

    exp_t sb[$];

    modinv_seq_if #(.WIDTH(16))  if16 ();
    modinv_seq_if #(.WIDTH(128)) if128 ();

    modinv_seq #(.WIDTH(16))  u_dut16  (.clk(clk), .rst_n(rst_n), .mi_if(if16));
    modinv_seq #(.WIDTH(128)) u_dut128 (.clk(clk), .rst_n(rst_n), .mi_if(if128));

    wire         done_w  = sel128 ? if128.done  : if16.done;
    wire         busy_w  = sel128 ? if128.busy  : if16.busy;
    wire         valid_w = sel128 ? if128.valid : if16.valid;
    wire [127:0] d_w     = sel128 ? if128.d     : {112'b0, if16.d};
    wire [15:0]  steps_w = sel128 ? if128.steps : if16.steps;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic v, input logic [127:0] d, input logic [15:0] steps, input int lat);
        exp_t x;
        x.v = v; x.d = d; x.steps = steps; x.lat = lat;
        sb.push_back(x);
    endtask

    // Reference extended Euclid using plain wide division.
    function automatic void ref_inv(input logic [127:0] e, input logic [127:0] phi,
                                    output logic v, output logic [127:0] d, output int steps);
        logic signed [135:0] r, nr, t, nt, q, tmp;
        v = 1'b0; d = '0; steps = 0;
        if (phi < 2 || e >= phi || e == 0) return;
        r = $signed({8'b0, phi}); nr = $signed({8'b0, e});
        t = 0; nt = 1;
        while (nr != 0) begin
            q = r / nr;
            tmp = r - q * nr; r = nr; nr = tmp;
            tmp = t - q * nt; t = nt; nt = tmp;
            steps++;
        end
        if (r == 1) begin
            if (t < 0) t = t + $signed({8'b0, phi});
            v = 1'b1;
            d = t[127:0];
        end
    endfunction

    task automatic drive_start(input bit w, input logic [127:0] e, input logic [127:0] phi);
        sel128 = w;
        if (w) begin
            if128.e = e; if128.phi = phi; if128.start = 1'b1;
        end else begin
            if16.e = e[15:0]; if16.phi = phi[15:0]; if16.start = 1'b1;
        end
    endtask

    // Called #1 after an edge; counts edges until done is seen high.
    task automatic wait_done(input int glitch_at, output int cyc, output int busy_n);
        cyc = 0; busy_n = 0;
        while (!done_w && cyc < BUDGET) begin
            if (busy_w) busy_n++;
            if (glitch_at > 0) begin
                if (cyc == glitch_at) begin
                    if16.e = 16'd3; if16.phi = 16'd7; if16.start = 1'b1;
                end else if (cyc == glitch_at + 1) begin
                    if16.start = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_val("done_seen", done_w, 1'b1);
    endtask

    task automatic compare_out(input string tag, input int cyc);
        exp_t x;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 1, 0);
            return;
        end
        x = sb.pop_front();
        check_val({tag, "_lat"},   cyc,     x.lat);
        check_val({tag, "_valid"}, valid_w, x.v);
        check_val({tag, "_d"},     d_w,     x.d);
        check_val({tag, "_steps"}, steps_w, x.steps);
    endtask

    task automatic run_chk(input string tag, input bit w, input logic [127:0] e,
                           input logic [127:0] phi, input int glitch_at);
        int cyc, busy_n;
        logic [127:0] d_keep;
        @(negedge clk);
        drive_start(w, e, phi);
        @(posedge clk); #1;
        if16.start = 1'b0; if128.start = 1'b0;
        wait_done(glitch_at, cyc, busy_n);
        check_val({tag, "_busy_cycles"}, busy_n, cyc - 1);
        d_keep = d_w;
        compare_out(tag, cyc);
        @(posedge clk); #1;
        check_val({tag, "_done_pulse"}, done_w, 1'b0);
        check_val({tag, "_d_hold"},     d_w,    d_keep);
    endtask

    initial begin
        int cyc, cyc2, busy_n, rst_done;
        logic         mv;
        logic [127:0] md;
        int           ms;
        logic [127:0] e128, phi128;
        logic [255:0] prod;

        rst_n = 1'b0; sel128 = 1'b0;
        if16.start = 1'b0;  if16.e = '0;  if16.phi = '0;
        if128.start = 1'b0; if128.e = '0; if128.phi = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out16", {if16.busy, if16.done, if16.valid, if16.steps, if16.d}, '0);
        check_val("rst_out128", {if128.busy, if128.done, if128.valid}, '0);
        check_val("rst_d128", if128.d, '0);
        @(negedge clk); rst_n = 1'b1;

        sb_push(1'b1, 128'd2753, 16'd4, 71);
        run_chk("rsa_17_3120", 1'b0, 128'd17, 128'd3120, 0);
        sb_push(1'b1, 128'd5, 16'd2, 37);
        run_chk("neg_t_3_7", 1'b0, 128'd3, 128'd7, 0);
        sb_push(1'b0, 128'd0, 16'd2, 37);
        run_chk("gcd3_6_9", 1'b0, 128'd6, 128'd9, 0);
        sb_push(1'b0, 128'd0, 16'd0, 3);
        run_chk("deg_e0", 1'b0, 128'd0, 128'd5, 0);
        sb_push(1'b0, 128'd0, 16'd0, 3);
        run_chk("deg_e_ge_phi", 1'b0, 128'd9, 128'd5, 0);
        sb_push(1'b0, 128'd0, 16'd0, 3);
        run_chk("deg_phi1", 1'b0, 128'd1, 128'd1, 0);

        // Second start pulse mid-run with different operands must be ignored.
        sb_push(1'b1, 128'd2753, 16'd4, 71);
        run_chk("start_busy", 1'b0, 128'd17, 128'd3120, 20);

        // Abort a run with reset while dividing.
        @(negedge clk);
        drive_start(1'b0, 128'd17, 128'd3120);
        @(posedge clk); #1;
        if16.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid", {if16.busy, if16.done, if16.valid, if16.steps, if16.d}, '0);
        rst_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (if16.done) rst_done++;
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (if16.done) rst_done++;
        end
        check_val("rst_no_done", rst_done, 0);
        sb_push(1'b1, 128'd2753, 16'd4, 71);
        run_chk("after_rst", 1'b0, 128'd17, 128'd3120, 0);

        // start held high: e=1 runs 1 step, then re-triggers one cycle after done.
        @(negedge clk);
        drive_start(1'b0, 128'd1, 128'd5);
        @(posedge clk); #1;
        sb_push(1'b1, 128'd1, 16'd1, 20);
        wait_done(0, cyc, busy_n);
        compare_out("hold_first", cyc);
        @(posedge clk); #1;
        wait_done(0, cyc2, busy_n);
        if16.start = 1'b0;
        sb_push(1'b1, 128'd1, 16'd1, 20);
        compare_out("hold_second", cyc2);
        check_val("hold_gap", 1 + cyc2, 21);
        @(posedge clk); #1;
        check_val("hold_idle", if16.busy, 1'b0);

        // Full-width RSA-style case.
        e128   = 128'd65537;
        phi128 = ~128'd0 - 128'd158;
        ref_inv(e128, phi128, mv, md, ms);
        sb_push(mv, md, 16'(ms), 3 + ms * 129);
        run_chk("w128", 1'b1, e128, phi128, 0);
        prod = {128'b0, e128} * {128'b0, if128.d};
        check_val("w128_mod_one", prod % {128'b0, phi128}, 128'd1);
        check_val("w128_model_valid", mv, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
